// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// funct codes, ALU control codes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // States that wait on mem_ready and are therefore covered by the timeout.
  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/alu_ctl_decode.sv
// R-type funct to ALU control decode; unsupported funct reports invalid
// and falls back to add so the ALU sees a benign operation.
module alu_ctl_decode
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctl_o,
  output logic       valid_o
);

  always_comb begin
    alu_ctl_o = ALU_ADD;
    valid_o   = 1'b1;
    case (funct_i)
      FN_ADD:  alu_ctl_o = ALU_ADD;
      FN_SUB:  alu_ctl_o = ALU_SUB;
      FN_AND:  alu_ctl_o = ALU_AND;
      FN_OR:   alu_ctl_o = ALU_OR;
      FN_SLT:  alu_ctl_o = ALU_SLT;
      default: valid_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: Moore decode of state, with mem_ready-gated
// enables, branch pc_write from zero, and a memory-wait timeout.
module mc_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_ctl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       retire,
  output logic       illegal,
  output logic       mem_err
);

  localparam int            CW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit            TO_EN    = (MEM_TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_sw_q, is_sw_d;
  logic [3:0]    dec_ctl;
  logic          dec_valid;
  logic          timeout;

  alu_ctl_decode u_alu_dec (
    .funct_i   (funct),
    .alu_ctl_o (dec_ctl),
    .valid_o   (dec_valid)
  );

  assign timeout = TO_EN && is_mem_state(state_q) && !mem_ready && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    is_sw_d    = is_sw_q;
    alu_ctl    = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PC_ALU;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          mem_err = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_RTYPE: state_d = S_R_EXEC;
          OP_LW: begin
            state_d = S_MEM_ADDR;
            is_sw_d = 1'b0;
          end
          OP_SW: begin
            state_d = S_MEM_ADDR;
            is_sw_d = 1'b1;
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDI_EXEC;
          OP_J:    state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = is_sw_q ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctl   = dec_ctl;
        if (dec_valid) begin
          state_d = S_R_WB;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctl   = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = PC_JUMP;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset overrides everything, including the otherwise-default add code.
    if (!rst_n) begin
      alu_ctl    = 4'b0000;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      retire     = 1'b0;
      illegal    = 1'b0;
      mem_err    = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || timeout) begin
      cnt_d = '0;
    end else if (TO_EN && is_mem_state(state_q) && !mem_ready) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_sw_q <= is_sw_d;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Table-driven bench for mc_control: each record is one clock of inputs plus
// the outputs expected during that clock; expectations go through a queue.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] alu_ctl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_write, ir_write, iord, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, reg_write, retire, illegal, mem_err;

  mc_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_ctl(alu_ctl), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_write(pc_write),
    .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .retire(retire), .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] pcs;
    logic pcw, irw, iord, mr, mw, m2r, rd, rw, ret, ill, err;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    out_t       exp;
  } vec_t;

  localparam logic [10:0] F_PCW = 11'd1 << 10, F_IRW = 11'd1 << 9, F_IORD = 11'd1 << 8;
  localparam logic [10:0] F_MR = 11'd1 << 7, F_MW = 11'd1 << 6, F_M2R = 11'd1 << 5;
  localparam logic [10:0] F_RD = 11'd1 << 4, F_RW = 11'd1 << 3, F_RET = 11'd1 << 2;
  localparam logic [10:0] F_ILL = 11'd1 << 1, F_ERR = 11'd1;

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0111;

  localparam out_t RST     = '0;
  localparam out_t F_WAIT  = {A_ADD, 1'b0, 2'b01, 2'b00, F_MR};
  localparam out_t F_GO    = {A_ADD, 1'b0, 2'b01, 2'b00, F_MR | F_IRW | F_PCW};
  localparam out_t F_TO    = {A_ADD, 1'b0, 2'b01, 2'b00, F_MR | F_ERR};
  localparam out_t DEC     = {A_ADD, 1'b0, 2'b11, 2'b00, 11'd0};
  localparam out_t DEC_ILL = {A_ADD, 1'b0, 2'b11, 2'b00, F_ILL};
  localparam out_t MADDR   = {A_ADD, 1'b1, 2'b10, 2'b00, 11'd0};
  localparam out_t MREAD   = {A_ADD, 1'b0, 2'b00, 2'b00, F_MR | F_IORD};
  localparam out_t MWB     = {A_ADD, 1'b0, 2'b00, 2'b00, F_RW | F_M2R | F_RET};
  localparam out_t MW_WAIT = {A_ADD, 1'b0, 2'b00, 2'b00, F_MW | F_IORD};
  localparam out_t MW_GO   = {A_ADD, 1'b0, 2'b00, 2'b00, F_MW | F_IORD | F_RET};
  localparam out_t MW_TO   = {A_ADD, 1'b0, 2'b00, 2'b00, F_MW | F_IORD | F_ERR};
  localparam out_t R_ILL   = {A_ADD, 1'b1, 2'b00, 2'b00, F_ILL};
  localparam out_t RWB     = {A_ADD, 1'b0, 2'b00, 2'b00, F_RW | F_RD | F_RET};
  localparam out_t BR_T    = {A_SUB, 1'b1, 2'b00, 2'b01, F_PCW | F_RET};
  localparam out_t BR_N    = {A_SUB, 1'b1, 2'b00, 2'b01, F_RET};
  localparam out_t AEXEC   = {A_ADD, 1'b1, 2'b10, 2'b00, 11'd0};
  localparam out_t AWB     = {A_ADD, 1'b0, 2'b00, 2'b00, F_RW | F_RET};
  localparam out_t JMP     = {A_ADD, 1'b0, 2'b00, 2'b10, F_PCW | F_RET};

  localparam logic [5:0] O_R = 6'h00, O_LW = 6'h23, O_SW = 6'h2B, O_BEQ = 6'h04;
  localparam logic [5:0] O_ADDI = 6'h08, O_J = 6'h02, O_BAD = 6'h3F;

  out_t got;
  assign got = {alu_ctl, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, iord,
                mem_read, mem_write, mem_to_reg, reg_dst, reg_write, retire, illegal, mem_err};

  int   n_vec = 0;
  int   n_err = 0;
  out_t sb_q[$];
  vec_t vq[$];

  function automatic out_t rexec(logic [3:0] c);
    return {c, 1'b1, 2'b00, 2'b00, 11'd0};
  endfunction

  function automatic vec_t mkv(logic r, logic [5:0] op, logic [5:0] fn, logic z, logic rdy, out_t e);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e;
    return v;
  endfunction

  task automatic push(logic [5:0] op, logic [5:0] fn, logic z, logic rdy, out_t e);
    vq.push_back(mkv(1'b1, op, fn, z, rdy, e));
  endtask

  task automatic push_r(logic [5:0] fn, logic [3:0] c);
    push(O_R, fn, 1'b0, 1'b1, F_GO);
    push(O_R, fn, 1'b0, 1'b1, DEC);
    push(O_R, fn, 1'b0, 1'b1, rexec(c));
    push(O_R, fn, 1'b0, 1'b1, RWB);
  endtask

  task automatic step(input vec_t v);
    out_t e;
    rst_n = v.rst; opcode = v.op; funct = v.fn; zero = v.z; mem_ready = v.rdy;
    sb_q.push_back(v.exp);
    @(negedge clk);
    e = sb_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL vec%0d: got %h expected %h", n_vec, got, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hs(logic r, logic [5:0] op, logic rdy, out_t e);
    step(mkv(r, op, 6'h20, 1'b0, rdy, e));
  endtask

  initial begin
    vq.push_back(mkv(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, RST));
    vq.push_back(mkv(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, RST));
    push_r(6'h20, A_ADD);
    push_r(6'h22, A_SUB);
    push_r(6'h24, A_AND);
    push_r(6'h25, A_OR);
    push_r(6'h2A, A_SLT);
    push(O_BEQ, 6'h00, 1'b1, 1'b1, F_GO);
    push(O_BEQ, 6'h00, 1'b1, 1'b1, DEC);
    push(O_BEQ, 6'h00, 1'b1, 1'b1, BR_T);
    push(O_BEQ, 6'h00, 1'b0, 1'b1, F_GO);
    push(O_BEQ, 6'h00, 1'b0, 1'b1, DEC);
    push(O_BEQ, 6'h00, 1'b0, 1'b1, BR_N);
    push(O_LW, 6'h00, 1'b0, 1'b1, F_GO);
    push(O_LW, 6'h00, 1'b0, 1'b1, DEC);
    push(O_LW, 6'h00, 1'b0, 1'b1, MADDR);
    push(O_LW, 6'h00, 1'b0, 1'b0, MREAD);
    push(O_LW, 6'h00, 1'b0, 1'b0, MREAD);
    push(O_LW, 6'h00, 1'b0, 1'b0, MREAD);
    push(O_LW, 6'h00, 1'b0, 1'b1, MREAD);
    push(O_LW, 6'h00, 1'b0, 1'b1, MWB);
    push(O_SW, 6'h00, 1'b0, 1'b1, F_GO);
    push(O_SW, 6'h00, 1'b0, 1'b1, DEC);
    push(O_SW, 6'h00, 1'b0, 1'b1, MADDR);
    push(O_SW, 6'h00, 1'b0, 1'b1, MW_GO);
    push(O_ADDI, 6'h00, 1'b0, 1'b1, F_GO);
    push(O_ADDI, 6'h00, 1'b0, 1'b1, DEC);
    push(O_ADDI, 6'h00, 1'b0, 1'b1, AEXEC);
    push(O_ADDI, 6'h00, 1'b0, 1'b1, AWB);
    push(O_J, 6'h00, 1'b0, 1'b1, F_GO);
    push(O_J, 6'h00, 1'b0, 1'b1, DEC);
    push(O_J, 6'h00, 1'b0, 1'b1, JMP);
    push(O_BAD, 6'h00, 1'b0, 1'b1, F_GO);
    push(O_BAD, 6'h00, 1'b0, 1'b1, DEC_ILL);
    push(O_R, 6'h00, 1'b0, 1'b1, F_GO);
    push(O_R, 6'h00, 1'b0, 1'b1, DEC);
    push(O_R, 6'h00, 1'b0, 1'b1, R_ILL);
    push(O_R, 6'h00, 1'b0, 1'b1, F_GO);
    push(O_R, 6'h00, 1'b0, 1'b1, DEC);
    push(O_R, 6'h00, 1'b0, 1'b1, R_ILL);

    @(posedge clk);
    #1;
    foreach (vq[i]) step(vq[i]);

    // FETCH timeout twice in a row, then mem_ready on the timeout cycle wins.
    for (int k = 0; k < 2; k++) begin
      hs(1'b1, O_J, 1'b0, F_WAIT);
      hs(1'b1, O_J, 1'b0, F_WAIT);
      hs(1'b1, O_J, 1'b0, F_WAIT);
      hs(1'b1, O_J, 1'b0, F_TO);
    end
    hs(1'b1, O_J, 1'b0, F_WAIT);
    hs(1'b1, O_J, 1'b0, F_WAIT);
    hs(1'b1, O_J, 1'b0, F_WAIT);
    hs(1'b1, O_J, 1'b1, F_GO);
    hs(1'b1, O_J, 1'b1, DEC);
    hs(1'b1, O_J, 1'b1, JMP);

    // Store that times out waiting in MEM_WRITE.
    hs(1'b1, O_SW, 1'b1, F_GO);
    hs(1'b1, O_SW, 1'b1, DEC);
    hs(1'b1, O_SW, 1'b1, MADDR);
    hs(1'b1, O_SW, 1'b0, MW_WAIT);
    hs(1'b1, O_SW, 1'b0, MW_WAIT);
    hs(1'b1, O_SW, 1'b0, MW_WAIT);
    hs(1'b1, O_SW, 1'b0, MW_TO);

    // Reset asserted mid-store, with mem_ready high, then normal restart.
    hs(1'b1, O_SW, 1'b1, F_GO);
    hs(1'b1, O_SW, 1'b1, DEC);
    hs(1'b1, O_SW, 1'b1, MADDR);
    hs(1'b1, O_SW, 1'b0, MW_WAIT);
    hs(1'b0, O_SW, 1'b1, RST);
    hs(1'b1, O_J, 1'b0, F_WAIT);
    hs(1'b1, O_J, 1'b1, F_GO);
    hs(1'b1, O_J, 1'b1, DEC);
    hs(1'b1, O_J, 1'b1, JMP);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
